// File: rtl/pkwars_video_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pkwars_video_pkg                                                         |
// | Shared types and constants for the video RAM scheduler: the slot owner   |
// | encoding, the BG fetch phase codes and the default RAM address width.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pkwars_video_pkg;

  // Owner of a video RAM slot, chosen once per pixel clock.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_BG   = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_DMA  = 2'd3
  } owner_e;

  // BG fetch phases; these equal HPOS[1:0] of the fetch slot.
  localparam logic [1:0] PH_NAME = 2'd0;
  localparam logic [1:0] PH_ATTR = 2'd1;
  localparam logic [1:0] PH_PAT  = 2'd2;

  // Default video RAM address width.
  localparam int AW_DEF = 11;

endpackage : pkwars_video_pkg
`default_nettype wire

// File: rtl/pkwars_slot_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pkwars_slot_arb                                                          |
// | Combinational slot-owner chooser plus the DMA starvation counter.        |
// | Ports:                                                                   |
// |   clk, rst_n          pixel clock, async active-low reset                |
// |   hpos                HPOS[1:0] (slot within a 4-pixel group)            |
// |   hblk, vblk          blanking flags                                     |
// |   cpu_req, cpu_blk    CPU request and "already granted" block            |
// |   dma_req             sprite DMA request                                 |
// |   owner, phase        chosen owner and BG phase for this cycle           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pkwars_slot_arb
  import pkwars_video_pkg::*;
#(
  parameter int STARVE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] hpos,
  input  logic       hblk,
  input  logic       vblk,
  input  logic       cpu_req,
  input  logic       cpu_blk,
  input  logic       dma_req,
  output owner_e     owner,
  output logic [1:0] phase
);

  localparam int CW = $clog2(STARVE + 1);

  logic [CW-1:0] starve_q;
  logic [CW-1:0] starve_d;
  logic          cpu_ok;

  always_comb begin
    owner    = OWN_NONE;
    phase    = PH_NAME;
    starve_d = starve_q;
    // A request that was already granted and is waiting for its ack is not
    // eligible again; the bridge drops CPU_REQ once it sees the ack.
    cpu_ok   = cpu_req & ~cpu_blk;

    if (!hblk && !vblk) begin
      // Active display: three fixed tile-fetch slots, one CPU slot.
      // The starve counter is left alone; DMA cannot run here.
      if (hpos != 2'd3) begin
        owner = OWN_BG;
        phase = hpos;
      end else if (cpu_ok) begin
        owner = OWN_CPU;
      end
    end else if (dma_req && (starve_q < CW'(STARVE))) begin
      owner = OWN_DMA;
      // Only a CPU request that is actually waiting counts toward starvation.
      if (cpu_ok) begin
        starve_d = starve_q + 1'b1;
      end
    end else if (cpu_ok) begin
      owner    = OWN_CPU;
      starve_d = '0;
    end else begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule : pkwars_slot_arb
`default_nettype wire

// File: rtl/pkwars_vram_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pkwars_vram_sched                                                        |
// | Time-slot scheduler for the single-port video RAM shared by BG tile      |
// | fetch, the CPU bridge and sprite-attribute DMA.                          |
// | Ports:                                                                   |
// |   PCLK, RSTn                  pixel clock, async active-low reset        |
// |   HPOS, HBLK, VBLK            beam position and blanking                 |
// |   BG_AD / BG_STB, BG_PH       tile fetch address / data strobe, phase    |
// |   CPU_REQ, CPU_WE, CPU_AD,    CPU request side                           |
// |   CPU_DO / CPU_DI, CPU_ACK,   CPU read data, completion, Z80 WAIT        |
// |   CPU_WAIT                                                               |
// |   DMA_REQ, DMA_AD / DMA_GNT   sprite DMA request / data strobe           |
// |   VA, VWE, VDO / VDI          RAM address, write, data out / data in     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pkwars_vram_sched
  import pkwars_video_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int STARVE = 8
) (
  input  logic          PCLK,
  input  logic          RSTn,
  input  logic [8:0]    HPOS,
  input  logic          HBLK,
  input  logic          VBLK,
  input  logic [AW-1:0] BG_AD,
  output logic          BG_STB,
  output logic [1:0]    BG_PH,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_AD,
  input  logic [7:0]    CPU_DO,
  output logic [7:0]    CPU_DI,
  output logic          CPU_ACK,
  output logic          CPU_WAIT,
  input  logic          DMA_REQ,
  input  logic [AW-1:0] DMA_AD,
  output logic          DMA_GNT,
  output logic [AW-1:0] VA,
  output logic          VWE,
  output logic [7:0]    VDO,
  input  logic [7:0]    VDI
);

  owner_e        owner;
  logic [1:0]    phase;

  // RAM-side registers (grant edge)
  owner_e        owner_q;
  logic [1:0]    ph_q;
  logic [AW-1:0] va_q,  va_d;
  logic          vwe_q, vwe_d;
  logic [7:0]    vdo_q, vdo_d;
  logic          pend_q, pend_d;

  // Strobe pipeline (data edge)
  logic          bg_stb_q, bg_stb_d;
  logic [1:0]    bg_ph_q,  bg_ph_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          cpu_rd_q,  cpu_rd_d;
  logic          dma_gnt_q, dma_gnt_d;
  logic [7:0]    cpu_di_q,  cpu_di_d;

  // Only the slot index within a 4-pixel group matters to scheduling.
  logic          unused_hpos_hi;
  assign unused_hpos_hi = ^HPOS[8:2];

  pkwars_slot_arb #(
    .STARVE (STARVE)
  ) u_arb (
    .clk     (PCLK),
    .rst_n   (RSTn),
    .hpos    (HPOS[1:0]),
    .hblk    (HBLK),
    .vblk    (VBLK),
    .cpu_req (CPU_REQ),
    .cpu_blk (pend_q | cpu_ack_q),
    .dma_req (DMA_REQ),
    .owner   (owner),
    .phase   (phase)
  );

  always_comb begin
    va_d   = va_q;
    vwe_d  = 1'b0;
    vdo_d  = 8'h00;
    pend_d = (owner == OWN_CPU);
    unique case (owner)
      OWN_BG:  va_d = BG_AD;
      OWN_CPU: begin
        va_d  = CPU_AD;
        vwe_d = CPU_WE;
        vdo_d = CPU_DO;
      end
      OWN_DMA: va_d = DMA_AD;
      default: ;
    endcase

    bg_stb_d  = (owner_q == OWN_BG);
    bg_ph_d   = ph_q;
    cpu_ack_d = (owner_q == OWN_CPU);
    cpu_rd_d  = (owner_q == OWN_CPU) & ~vwe_q;
    dma_gnt_d = (owner_q == OWN_DMA);
    // Read data arrives in the ack cycle; capture it so CPU_DI keeps it
    // until the next CPU read completes.
    cpu_di_d  = (cpu_ack_q & cpu_rd_q) ? VDI : cpu_di_q;
  end

  always_ff @(posedge PCLK or negedge RSTn) begin
    if (!RSTn) begin
      owner_q   <= OWN_NONE;
      ph_q      <= PH_NAME;
      va_q      <= '0;
      vwe_q     <= 1'b0;
      vdo_q     <= 8'h00;
      pend_q    <= 1'b0;
      bg_stb_q  <= 1'b0;
      bg_ph_q   <= PH_NAME;
      cpu_ack_q <= 1'b0;
      cpu_rd_q  <= 1'b0;
      dma_gnt_q <= 1'b0;
      cpu_di_q  <= 8'h00;
    end else begin
      owner_q   <= owner;
      ph_q      <= phase;
      va_q      <= va_d;
      vwe_q     <= vwe_d;
      vdo_q     <= vdo_d;
      pend_q    <= pend_d;
      bg_stb_q  <= bg_stb_d;
      bg_ph_q   <= bg_ph_d;
      cpu_ack_q <= cpu_ack_d;
      cpu_rd_q  <= cpu_rd_d;
      dma_gnt_q <= dma_gnt_d;
      cpu_di_q  <= cpu_di_d;
    end
  end

  assign VA       = va_q;
  assign VWE      = vwe_q;
  assign VDO      = vdo_q;
  assign BG_STB   = bg_stb_q;
  assign BG_PH    = bg_ph_q;
  assign CPU_ACK  = cpu_ack_q;
  assign DMA_GNT  = dma_gnt_q;
  assign CPU_DI   = (cpu_ack_q & cpu_rd_q) ? VDI : cpu_di_q;
  assign CPU_WAIT = CPU_REQ & ~cpu_ack_q;

endmodule : pkwars_vram_sched
`default_nettype wire
